// File: rtl/prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package prefetch_buffer_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RUN        = 2'd1,
      FLUSH_WAIT = 2'd2
   } prefetch_state_e;

   typedef struct packed {
      logic [WORD_WIDTH-1:0] pc;
      logic [WORD_WIDTH-1:0] instr;
   } prefetch_entry_t;

   function automatic logic [WORD_WIDTH-1:0] word_align(input logic [WORD_WIDTH-1:0] addr);
      return {addr[WORD_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/prefetch_buffer_if.sv
// Memory-port and IF-stage signals of the prefetch buffer; master is the buffer side.
interface prefetch_buffer_if;
   import prefetch_buffer_pkg::*;

   logic                  fetch_en_i;
   logic [WORD_WIDTH-1:0] pc_start_addr_i;
   logic                  branch_i;
   logic [WORD_WIDTH-1:0] branch_addr_i;
   logic                  mem_req_o;
   logic [WORD_WIDTH-1:0] mem_addr_o;
   logic                  mem_gnt_i;
   logic                  mem_rvalid_i;
   logic [WORD_WIDTH-1:0] mem_rdata_i;
   logic                  fetch_valid_o;
   logic [WORD_WIDTH-1:0] fetch_rdata_o;
   logic [WORD_WIDTH-1:0] fetch_pc_o;
   logic                  fetch_ready_i;

   modport master (
      input  fetch_en_i, pc_start_addr_i, branch_i, branch_addr_i,
             mem_gnt_i, mem_rvalid_i, mem_rdata_i, fetch_ready_i,
      output mem_req_o, mem_addr_o, fetch_valid_o, fetch_rdata_o, fetch_pc_o
   );

   modport slave (
      output fetch_en_i, pc_start_addr_i, branch_i, branch_addr_i,
             mem_gnt_i, mem_rvalid_i, mem_rdata_i, fetch_ready_i,
      input  mem_req_o, mem_addr_o, fetch_valid_o, fetch_rdata_o, fetch_pc_o
   );

endinterface

// File: rtl/prefetch_buffer_fifo.sv
// Synchronous FIFO of PC/instruction pairs with a synchronous clear.
module prefetch_fifo
   import prefetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  prefetch_entry_t        push_data,
   output prefetch_entry_t        head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   prefetch_entry_t mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: entries are only visible through a nonzero count.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetch buffer: issues word fetches, tags responses with their PC, flushes on branches.
module prefetch_buffer
   import prefetch_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   prefetch_buffer_if.master  bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [1:0] S_IDLE       = IDLE;
   localparam logic [1:0] S_RUN        = RUN;
   localparam logic [1:0] S_FLUSH_WAIT = FLUSH_WAIT;

   logic [1:0]            state;
   logic [WORD_WIDTH-1:0] fetch_addr;
   logic [WORD_WIDTH-1:0] redirect_addr;
   logic [WORD_WIDTH-1:0] resp_pc;
   logic [WORD_WIDTH-1:0] target;
   logic [CW-1:0]         outstanding;
   logic [CW-1:0]         discard;
   logic [CW-1:0]         out_next;
   logic [CW-1:0]         fifo_count;
   logic                  hold;
   logic                  credit;
   logic                  req;
   logic                  grant;
   logic                  branch;
   logic                  rsp_keep;
   logic                  rsp_drop;
   logic                  push;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   prefetch_entry_t       head;
   prefetch_entry_t       push_entry;

   assign target   = word_align(bus.branch_addr_i);
   assign branch   = bus.branch_i && (state != S_IDLE);
   assign credit   = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
   // Once raised, a request stays up (hold) until granted, whatever else changes.
   assign req      = hold || ((state == S_RUN) && bus.fetch_en_i && !bus.branch_i && credit);
   assign grant    = req && bus.mem_gnt_i;
   assign rsp_drop = bus.mem_rvalid_i && (discard != '0);
   assign rsp_keep = bus.mem_rvalid_i && (discard == '0);
   assign out_next = outstanding + CW'(grant) - CW'(bus.mem_rvalid_i);

   assign push       = rsp_keep && !branch;
   assign pop        = !fifo_empty && bus.fetch_ready_i && !branch;
   assign push_entry = '{pc: resp_pc, instr: bus.mem_rdata_i};

   assign bus.mem_req_o     = req;
   assign bus.mem_addr_o    = fetch_addr;
   assign bus.fetch_valid_o = !fifo_empty;
   assign bus.fetch_rdata_o = fifo_empty ? '0 : head.instr;
   assign bus.fetch_pc_o    = fifo_empty ? '0 : head.pc;

   prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .clear     (branch),
      .push_data (push_entry),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         fetch_addr    <= '0;
         redirect_addr <= '0;
         resp_pc       <= '0;
         outstanding   <= '0;
         discard       <= '0;
         hold          <= 1'b0;
      end else begin
         outstanding <= out_next;
         hold        <= req && !bus.mem_gnt_i;

         // Everything still in flight after a branch belongs to the old path.
         if (state == S_IDLE)  discard <= '0;
         else if (branch)      discard <= out_next;
         else                  discard <= discard - CW'(rsp_drop)
                                          + CW'(grant && (state == S_FLUSH_WAIT));

         if (state == S_IDLE)  resp_pc <= bus.pc_start_addr_i;
         else if (branch)      resp_pc <= target;
         else if (push)        resp_pc <= resp_pc + 32'd4;

         case (state)
            S_IDLE: begin
               fetch_addr <= bus.pc_start_addr_i;
               if (bus.fetch_en_i) state <= S_RUN;
            end
            S_RUN: begin
               if (branch) begin
                  if (req && !bus.mem_gnt_i) begin
                     redirect_addr <= target;
                     state         <= S_FLUSH_WAIT;
                  end else begin
                     fetch_addr <= target;
                  end
               end else if (grant) begin
                  fetch_addr <= fetch_addr + 32'd4;
               end
            end
            S_FLUSH_WAIT: begin
               if (branch) redirect_addr <= target;
               if (grant) begin
                  fetch_addr <= branch ? target : redirect_addr;
                  state      <= S_RUN;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
      !(bus.mem_rvalid_i && (discard == '0) && fifo_full));

endmodule

// File: tb/tb_prefetch_buffer.sv
// Self-checking bench: a memory/IF-stage model plus an in-order PC/data reference stream.
module tb_prefetch_buffer;
   import prefetch_buffer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   prefetch_buffer_if bus();

   prefetch_buffer #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          grants = 0;
   int          pops = 0;
   int          gnt_mode = 0;
   int          rsp_min = 0;
   int          rsp_max = 0;
   int          gnt_wait = -1;
   int          base;
   logic [31:0] exp_pc;
   logic [31:0] exp_grants[$];
   pend_t       pend[$];
   logic        prev_req = 1'b0;
   logic        prev_gnt = 1'b0;
   logic        prev_branch = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        s_req;
   logic [31:0] s_addr;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, model memory and IF stage, compare against the reference stream.
   task automatic applyStimulus(input logic en, input logic ready, input logic br,
                                input logic [31:0] br_addr, input logic gnt_block);
      pend_t p;
      @(negedge clk);
      cyc++;
      bus.fetch_en_i    = en;
      bus.fetch_ready_i = ready;
      bus.branch_i      = br;
      bus.branch_addr_i = br_addr;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.mem_rvalid_i = 1'b1;
         bus.mem_rdata_i  = instr_of(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         bus.mem_rvalid_i = 1'b0;
         bus.mem_rdata_i  = $urandom;
      end
      #1;
      s_req  = bus.mem_req_o;
      s_addr = bus.mem_addr_o;
      if (!s_req) gnt_wait = -1;
      else if (gnt_wait < 0) gnt_wait = (gnt_mode != 0) ? int'($urandom_range(0, 3)) : 0;
      bus.mem_gnt_i = s_req && (gnt_wait == 0) && !gnt_block;
      if (bus.mem_gnt_i) gnt_wait = -1;
      else if (gnt_wait > 0 && !gnt_block) gnt_wait--;
      #1;
      if (prev_req && !prev_gnt) begin
         checkOutput("req_held", 32'(s_req), 32'd1);
         checkOutput("addr_held", s_addr, prev_addr);
      end
      if (prev_branch) checkOutput("valid_after_branch", 32'(bus.fetch_valid_o), 32'd0);
      if (bus.fetch_valid_o && ready && !br) begin
         checkOutput("head_pc", bus.fetch_pc_o, exp_pc);
         checkOutput("head_instr", bus.fetch_rdata_o, instr_of(exp_pc));
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      if (br) exp_pc = {br_addr[31:2], 2'b00};
      if (bus.mem_gnt_i) begin
         grants++;
         if (exp_grants.size() > 0) checkOutput("grant_addr", s_addr, exp_grants.pop_front());
         p.addr = s_addr;
         p.due  = cyc + 1 + int'($urandom_range(rsp_min, rsp_max));
         pend.push_back(p);
      end
      prev_req    = s_req;
      prev_gnt    = bus.mem_gnt_i;
      prev_addr   = s_addr;
      prev_branch = br;
   endtask

   task automatic doReset(input logic [31:0] start);
      @(negedge clk);
      rst_n               = 1'b0;
      bus.fetch_en_i      = 1'b1;
      bus.pc_start_addr_i = start;
      bus.branch_i        = 1'b0;
      bus.branch_addr_i   = '0;
      bus.mem_gnt_i       = 1'b0;
      bus.mem_rvalid_i    = 1'b0;
      bus.mem_rdata_i     = '0;
      bus.fetch_ready_i   = 1'b0;
      #1;
      checkOutput("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
      checkOutput("rst_mem_addr", bus.mem_addr_o, 32'd0);
      checkOutput("rst_fetch_valid", 32'(bus.fetch_valid_o), 32'd0);
      checkOutput("rst_fetch_rdata", bus.fetch_rdata_o, 32'd0);
      checkOutput("rst_fetch_pc", bus.fetch_pc_o, 32'd0);
      pend.delete();
      exp_grants.delete();
      gnt_wait    = -1;
      prev_req    = 1'b0;
      prev_gnt    = 1'b0;
      prev_branch = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = start;
      grants = 0;
      pops   = 0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Boot: zero-wait memory streams one instruction per cycle.
      gnt_mode = 0; rsp_min = 0; rsp_max = 0;
      doReset(32'h100);
      for (int i = 0; i < 8; i++) exp_grants.push_back(32'h100 + 32'(4 * i));
      repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      base = pops;
      repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("boot_throughput", 32'(pops - base), 32'd20);
      checkOutput("boot_grants_seen", 32'(exp_grants.size()), 32'd0);

      // Backpressure: credit stops requests after DEPTH grants.
      doReset(32'h100);
      repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("bp_grants", 32'(grants), 32'd4);
      checkOutput("bp_req_low", 32'(s_req), 32'd0);
      checkOutput("bp_valid", 32'(bus.fetch_valid_o), 32'd1);
      checkOutput("bp_head_pc", bus.fetch_pc_o, 32'h100);
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("bp_resume", 32'(grants > 4), 32'd1);

      // Reset with a full queue, then re-boot from a new start PC.
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("full_before_reset", 32'(bus.fetch_valid_o), 32'd1);
      doReset(32'h300);
      exp_grants.push_back(32'h300);
      exp_grants.push_back(32'h304);
      repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("reboot_grants_seen", 32'(exp_grants.size()), 32'd0);
      checkOutput("reboot_pops", 32'(pops >= 4), 32'd1);

      // Branch with two responses still in flight.
      rsp_min = 3; rsp_max = 3;
      doReset(32'h100);
      for (int i = 0; i < 20 && grants < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("bif_two_grants", 32'(grants), 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h2003, 1'b0);
      exp_grants.push_back(32'h2000);
      exp_grants.push_back(32'h2004);
      repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("bif_grants_seen", 32'(exp_grants.size()), 32'd0);
      checkOutput("bif_pops", 32'(pops >= 2), 32'd1);

      // Branch while a request waits for its grant.
      rsp_min = 0; rsp_max = 0;
      doReset(32'h100);
      for (int i = 0; i < 20 && grants < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, (i == 2), 32'h400, 1'b1);
         checkOutput("ug_req", 32'(s_req), 32'd1);
         checkOutput("ug_addr", s_addr, 32'h10C);
      end
      exp_grants.push_back(32'h10C);
      exp_grants.push_back(32'h400);
      exp_grants.push_back(32'h404);
      repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("ug_grants_seen", 32'(exp_grants.size()), 32'd0);

      // Random grant/response delays, ready, enable and branches.
      $display("[TB] random phase");
      gnt_mode = 1; rsp_min = 0; rsp_max = 3;
      doReset($urandom & 32'h0000_FFFC);
      for (int i = 0; i < 3000; i++)
         applyStimulus($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 24) == 0, $urandom, 1'b0);
      checkOutput("rand_progress", 32'(pops > 100), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prefetch_buffer.md
# prefetch_buffer

Instruction prefetch buffer between the instruction-memory port and the IF stage of the RISC-V pipeline. It issues word fetches over the req/gnt/rvalid protocol and tags each returned instruction with its PC. Up to DEPTH instructions are queued in order for the IF stage. On a taken branch it flushes the queue, discards in-flight responses and redirects to the branch target.

## Interface
- WORD_WIDTH, 32, instruction/address width (from the shared defines package).
- DEPTH, 4, queue entries; power of two, ≥2.
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- fetch_en_i  in  1  enables issuing of new requests.
- pc_start_addr_i  in  WORD_WIDTH  boot PC, sampled while in IDLE.
- branch_i  in  1  taken branch/jump; flush and redirect.
- branch_addr_i  in  WORD_WIDTH  redirect target; bits [1:0] forced to 0.
- mem_req_o  out  1  fetch request.
- mem_addr_o  out  WORD_WIDTH  fetch address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  mem_rdata_i valid this cycle. Responses arrive in order, ≥1 cycle after gnt.
- mem_rdata_i  in  WORD_WIDTH  returned instruction.
- fetch_valid_o  out  1  queue head valid.
- fetch_rdata_o  out  WORD_WIDTH  queue head instruction.
- fetch_pc_o  out  WORD_WIDTH  PC of queue head.
- fetch_ready_i  in  1  IF stage consumes head when fetch_valid_o is also high.

## Operation
- States are IDLE, RUN and FLUSH_WAIT.
- **IDLE**
  - fetch_addr loads pc_start_addr_i and resp_pc loads pc_start_addr_i.
  - The block moves to RUN when fetch_en_i=1.
- **Request issue in RUN**
  - mem_req_o=1 when fetch_en_i=1, branch_i=0 and (count + outstanding) < DEPTH.
  - mem_addr_o = fetch_addr.
  - On req&gnt: fetch_addr += 4 and outstanding += 1.
  - Once mem_req_o rises, mem_req_o and mem_addr_o are held stable until gnt, even if the credit condition or fetch_en_i changes.
- **Response handling**
  - On mem_rvalid_i with discard=0: push {resp_pc, mem_rdata_i}, then resp_pc += 4 and outstanding −= 1.
  - On mem_rvalid_i with discard>0: drop the response and decrement both discard and outstanding.
- **Pop**: on fetch_valid_o & fetch_ready_i & !branch_i, the head is removed. A push and a pop in the same cycle leave count unchanged.
- **Branch (cycle N)**
  - The queue is cleared and any handshake in cycle N is ignored.
  - discard = outstanding, plus 1 if a grant occurs in cycle N.
  - resp_pc ← target.
  - If mem_req_o=1 and mem_gnt_i=0 in cycle N, go to FLUSH_WAIT with redirect_addr ← target. Otherwise fetch_addr ← target and stay in RUN.
- **FLUSH_WAIT**
  - The old request is held until gnt. That grant increments both outstanding and discard.
  - fetch_addr ← redirect_addr, then go to RUN.
  - A further branch_i in FLUSH_WAIT updates the redirect target and resp_pc, and sets discard = outstanding.
- fetch_en_i=0 in RUN stops new requests only. Pending grants and responses complete normally and the queue keeps draining.
- Overflow is impossible by credit. A response arriving with the queue full and no discard pending is a protocol error; assert it in simulation.

## Timing
- Reset values:
  - mem_req_o=0, mem_addr_o=0, fetch_valid_o=0, fetch_rdata_o=0, fetch_pc_o=0.
  - State IDLE; count, outstanding and discard all 0.
- Reset asserted mid-operation aborts everything immediately. Late rvalids after reset release are undefined system behaviour and are not handled.
- mem_req_o is asserted in the cycle after IDLE→RUN.
- Latency: rvalid in cycle N → fetch_valid_o in N+1 (registered queue, no bypass).
- After branch in cycle N: fetch_valid_o=0 from N+1, and the target request is issued at N+1 if credit allows. The first target instruction is visible 1 cycle after its non-discarded rvalid.
- Throughput: one instruction per cycle with a zero-wait memory, given DEPTH ≥ 2.

## Structure
- Shared package holds:
  - WORD_WIDTH.
  - prefetch_state_e (IDLE, RUN, FLUSH_WAIT).
  - The entry struct prefetch_entry_t {pc, instr}.
- Sub-module prefetch_fifo: generic synchronous FIFO of prefetch_entry_t.
  - Parameter DEPTH.
  - Ports push, pop, clear, full, empty, count.
  - Pointer wrap via a log2(DEPTH)-bit index; count is log2(DEPTH)+1 bits wide.
- Top: FSM, fetch_addr, redirect_addr, resp_pc, and outstanding/discard counters, each log2(DEPTH)+1 bits wide.

## Test plan
- **Boot**: pc_start_addr_i=0x100, fetch_en_i=1, gnt always 1, rvalid 1 cycle after gnt, fetch_ready_i=1 → requests to 0x100, 0x104, 0x108…; fetch_pc_o follows the same sequence with matching data, one per cycle.
- **Backpressure**: fetch_ready_i=0 with DEPTH=4 → exactly 4 grants, then mem_req_o=0. fetch_valid_o stays 1 with PC 0x100 until ready returns, then requests resume.
- **Branch with in-flight responses**: 2 outstanding requests, branch_i to 0x2003 → both responses dropped; next request at 0x2000; first output has fetch_pc_o=0x2000.
- **Branch while ungranted**: req at 0x10C held with gnt=0 for 3 cycles, branch_i to 0x400 → mem_addr_o stays 0x10C until gnt, its data is never output; next request is 0x400.
- **Random gnt/rvalid delays (0–3 cycles)** with random ready and random branches → PC/data pairs are in order with no gaps or duplicates, and the overflow assertion never fires.
- **Reset during RUN** with a full queue → all outputs return to 0 and state IDLE; after release the block re-boots from pc_start_addr_i.
